ctrl_multiciclo: RTL and testbench
==================================

Name: ctrl_multiciclo

Overview:
- Multicycle main control FSM for the MIPS-subset core. Directly upstream of the ALU control decoder.
- Decodes the instruction opcode into per-cycle datapath strobes and drives the 4-bit ALUOp that the ALU control decoder combines with funct.
- Sits between the instruction register and the datapath muxes, register-file enables and memory enables.

Parameters:
- ALUOP_ADD, 4'b0010, ALUOp value used for PC+4, branch target, and lw/sw address add. This value falls to the ALU control decoder's add default.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- opcode  input  6  instruction register bits [31:26]; stable from DECODE onward
- iord  output  1  memory address select: 0 = PC, 1 = ALUOut
- mem_write  output  1  data memory write strobe
- ir_write  output  1  instruction register load
- reg_dst  output  1  write register: 0 = rt, 1 = rd
- mem_to_reg  output  1  write data: 0 = ALUOut, 1 = MDR
- reg_write  output  1  register file write strobe
- alu_src_a  output  1  ALU A: 0 = PC, 1 = regA
- alu_src_b  output  2  ALU B: 00 = regB, 01 = 4, 10 = sign/zero-ext imm, 11 = sext imm<<2
- alu_op  output  4  ALUOp to the ALU control decoder
- zero_ext  output  1  immediate zero-extend (andi/ori/xori)
- pc_src  output  2  next PC: 00 = ALU result, 01 = ALUOut, 10 = jump target
- pc_write  output  1  unconditional PC load
- branch  output  1  beq: PC loads when ALU zero = 1
- branch_ne  output  1  bne: PC loads when ALU zero = 0
- illegal_op  output  1  one-cycle pulse in DECODE for an unsupported opcode
- state  output  4  current state encoding, for debug and verification

Behaviour:
- The state register is the only storage. All outputs are Moore, decoded from state.
- Defaults for every output: 0, except alu_op = ALUOP_ADD.
- Synchronous reset: at the clock edge with reset = 1, state becomes FETCH.
- While reset = 1, every strobe is forced to 0: pc_write, ir_write, mem_write, reg_write, branch, branch_ne, illegal_op.
- Reset mid-instruction abandons the instruction. No partial writes occur after the reset edge.
- State encodings and outputs:
  - FETCH 0: ir_write = 1, pc_write = 1, alu_src_b = 01, alu_op = ADD, iord = 0, pc_src = 00. Next state: DECODE.
  - DECODE 1: alu_src_b = 11, alu_op = ADD (branch target into ALUOut). Next state by opcode:
    - 000000 (R-type) -> EXECUTE
    - 100011 (lw) / 101011 (sw) -> MEMADR
    - 000100 (beq) / 000101 (bne) -> BRANCH
    - 001000, 001010, 001011, 001100, 001101, 001110 -> IMMEXEC
    - 000010 (j) -> JUMP
    - any other opcode -> FETCH, with illegal_op = 1 in this cycle
  - MEMADR 2: alu_src_a = 1, alu_src_b = 10, alu_op = ADD. Next: MEMREAD if lw, MEMWRITE if sw.
  - MEMREAD 3: iord = 1. Next: MEMWB.
  - MEMWB 4: reg_write = 1, mem_to_reg = 1, reg_dst = 0. Next: FETCH.
  - MEMWRITE 5: iord = 1, mem_write = 1. Next: FETCH.
  - EXECUTE 6: alu_src_a = 1, alu_src_b = 00, alu_op = 0000. Next: ALUWB.
  - ALUWB 7: reg_write = 1, reg_dst = 1, mem_to_reg = 0. Next: FETCH.
  - BRANCH 8: alu_src_a = 1, alu_src_b = 00, alu_op = opcode[3:0] (0100 or 0101), pc_src = 01. branch = 1 for beq, branch_ne = 1 for bne. Next: FETCH.
  - IMMEXEC 9: alu_src_a = 1, alu_src_b = 10, alu_op = opcode[3:0]. zero_ext = 1 when opcode[3:2] = 11. Next: IMMWB.
  - IMMWB 10: reg_write = 1, reg_dst = 0, mem_to_reg = 0. Next: FETCH.
  - JUMP 11: pc_src = 10, pc_write = 1. Next: FETCH.
  - Encodings 12-15 are unreachable. If entered, next state is FETCH with all strobes 0.
- sw must never present opcode[3:0] (1011) as alu_op. The low nibble of sw collides with sltiu, so MEMADR always drives ALUOP_ADD.
- Cycle counts from FETCH to the next FETCH: lw 5, sw 4, R-type 4, immediate 4, beq/bne 3, j 3, illegal 2.
- opcode is sampled only in DECODE, MEMADR, BRANCH and IMMEXEC. It is ignored in all other states.
- Mutually exclusive at all times: reg_write, mem_write and pc_write/branch/branch_ne never coexist except pc_write with ir_write in FETCH.

Test Plan:
- Reset 2 cycles, release -> state = 0, ir_write = 1, pc_write = 1, alu_op = 0010 on the first post-reset cycle; all strobes 0 while reset is high.
- lw (100011) -> states 0,1,2,3,4,0; mem_to_reg = 1 and reg_write = 1 only in state 4; iord = 1 in state 3.
- sw (101011) -> states 0,1,2,5,0; alu_op = 0010 in state 2 (never 1011); mem_write = 1 only in state 5.
- Immediates: ori (001101) -> state 9 with alu_op = 1101, zero_ext = 1. slti (001010) -> state 9 with alu_op = 1010, zero_ext = 0.
- Branches and jump: bne (000101) -> state 8 with alu_op = 0101, branch_ne = 1, branch = 0. j (000010) -> state 11 with pc_src = 10, pc_write = 1.
- Illegal opcode 111111 -> illegal_op = 1 for one cycle in state 1, then state 0. Reset asserted in state 3 of an lw -> next state 0, reg_write never pulses.

Source files
------------

// File: rtl/ctrl_multiciclo.sv
// ctrl_multiciclo: multicycle main control FSM for the MIPS-subset core.
// The state register is the only storage; every datapath strobe is a Moore
// decode of the current state (plus the held opcode where the state's
// behaviour depends on it). Reset forces all strobes low combinationally.
module ctrl_multiciclo #(
  parameter logic [3:0] ALUOP_ADD = 4'b0010
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  output logic       iord,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [3:0] alu_op,
  output logic       zero_ext,
  output logic [1:0] pc_src,
  output logic       pc_write,
  output logic       branch,
  output logic       branch_ne,
  output logic       illegal_op,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTE  = 4'd6,
    ALUWB    = 4'd7,
    BRANCH   = 4'd8,
    IMMEXEC  = 4'd9,
    IMMWB    = 4'd10,
    JUMP     = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;

  state_t state_q;

  // Immediate-ALU opcodes that share the IMMEXEC/IMMWB path.
  function automatic logic is_imm(input logic [5:0] op);
    case (op)
      OP_ADDI, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI: is_imm = 1'b1;
      default:                                              is_imm = 1'b0;
    endcase
  endfunction

  // Every opcode that DECODE dispatches somewhere other than back to FETCH.
  function automatic logic is_legal(input logic [5:0] op);
    case (op)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J: is_legal = 1'b1;
      default:                                      is_legal = is_imm(op);
    endcase
  endfunction

  // State register: synchronous reset to FETCH, opcode-driven dispatch.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCH;
    end else begin
      case (state_q)
        FETCH:  state_q <= DECODE;
        DECODE: begin
          if (opcode == OP_RTYPE)                      state_q <= EXECUTE;
          else if (opcode == OP_LW || opcode == OP_SW) state_q <= MEMADR;
          else if (opcode == OP_BEQ || opcode == OP_BNE) state_q <= BRANCH;
          else if (is_imm(opcode))                     state_q <= IMMEXEC;
          else if (opcode == OP_J)                     state_q <= JUMP;
          else                                         state_q <= FETCH;
        end
        MEMADR:   state_q <= (opcode == OP_SW) ? MEMWRITE : MEMREAD;
        MEMREAD:  state_q <= MEMWB;
        MEMWB:    state_q <= FETCH;
        MEMWRITE: state_q <= FETCH;
        EXECUTE:  state_q <= ALUWB;
        ALUWB:    state_q <= FETCH;
        BRANCH:   state_q <= FETCH;
        IMMEXEC:  state_q <= IMMWB;
        IMMWB:    state_q <= FETCH;
        JUMP:     state_q <= FETCH;
        default:  state_q <= FETCH;
      endcase
    end
  end

  // Moore output decode; reset overrides every write/load strobe.
  always_comb begin
    iord       = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = ALUOP_ADD;
    zero_ext   = 1'b0;
    pc_src     = 2'b00;
    pc_write   = 1'b0;
    branch     = 1'b0;
    branch_ne  = 1'b0;
    illegal_op = 1'b0;
    case (state_q)
      FETCH: begin
        ir_write  = 1'b1;
        pc_write  = 1'b1;
        alu_src_b = 2'b01;
      end
      DECODE: begin
        // Branch target is computed speculatively into ALUOut here.
        alu_src_b  = 2'b11;
        illegal_op = ~is_legal(opcode);
      end
      MEMADR: begin
        // Always add: sw's low opcode nibble would alias sltiu.
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      MEMREAD: iord = 1'b1;
      MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      MEMWRITE: begin
        iord      = 1'b1;
        mem_write = 1'b1;
      end
      EXECUTE: begin
        alu_src_a = 1'b1;
        alu_op    = 4'b0000;
      end
      ALUWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = opcode[3:0];
        pc_src    = 2'b01;
        branch    = (opcode == OP_BEQ);
        branch_ne = (opcode == OP_BNE);
      end
      IMMEXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op    = opcode[3:0];
        zero_ext  = (opcode[3:2] == 2'b11);
      end
      IMMWB: reg_write = 1'b1;
      JUMP: begin
        pc_src   = 2'b10;
        pc_write = 1'b1;
      end
      default: ;
    endcase
    if (reset) begin
      pc_write   = 1'b0;
      ir_write   = 1'b0;
      mem_write  = 1'b0;
      reg_write  = 1'b0;
      branch     = 1'b0;
      branch_ne  = 1'b0;
      illegal_op = 1'b0;
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_ctrl_multiciclo.sv
// Testbench for ctrl_multiciclo: each scenario pushes the expected output
// vector of every cycle into a scoreboard queue, then pops and compares one
// entry per clock, sampling 1 time unit after the falling edge.
module tb_ctrl_multiciclo;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode;
  logic       iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write;
  logic       alu_src_a, zero_ext, pc_write, branch, branch_ne, illegal_op;
  logic [1:0] alu_src_b, pc_src;
  logic [3:0] alu_op, state;

  int checks   = 0;
  int failures = 0;
  logic [23:0] sb[$];
  logic [23:0] exp_v;
  logic [23:0] act_v;

  ctrl_multiciclo dut (
    .clk(clk), .reset(reset), .opcode(opcode),
    .iord(iord), .mem_write(mem_write), .ir_write(ir_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .zero_ext(zero_ext), .pc_src(pc_src), .pc_write(pc_write),
    .branch(branch), .branch_ne(branch_ne), .illegal_op(illegal_op),
    .state(state)
  );

  always #5 clk = ~clk;

  assign act_v = {state, iord, mem_write, ir_write, reg_dst, mem_to_reg,
                  reg_write, alu_src_a, alu_src_b, alu_op, zero_ext, pc_src,
                  pc_write, branch, branch_ne, illegal_op};

  // Pack an expected output set in the same order as act_v.
  function automatic logic [23:0] mk(
      input logic [3:0] st, input logic io, input logic mw, input logic irw,
      input logic rd, input logic m2r, input logic rw, input logic sa,
      input logic [1:0] sb_, input logic [3:0] op, input logic ze,
      input logic [1:0] ps, input logic pw, input logic br, input logic bn,
      input logic il);
    mk = {st, io, mw, irw, rd, m2r, rw, sa, sb_, op, ze, ps, pw, br, bn, il};
  endfunction

  //                       st  io mw ir rd mr rw sa sb     op       ze ps     pw br bn il
  localparam logic [23:0] E_RST    = {4'd0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,4'b0010,1'b0,2'b00,1'b0,1'b0,1'b0,1'b0};
  logic [23:0] E_FETCH, E_DEC, E_DEC_ILL, E_MEMADR, E_MEMRD, E_MEMWB, E_MEMWR;
  logic [23:0] E_EXE, E_ALUWB, E_IMMWB, E_JUMP, E_MEMRD_RST;

  initial begin
    E_FETCH     = mk(4'd0, 0,0,1,0,0,0,0, 2'b01, 4'b0010, 0, 2'b00, 1,0,0,0);
    E_DEC       = mk(4'd1, 0,0,0,0,0,0,0, 2'b11, 4'b0010, 0, 2'b00, 0,0,0,0);
    E_DEC_ILL   = mk(4'd1, 0,0,0,0,0,0,0, 2'b11, 4'b0010, 0, 2'b00, 0,0,0,1);
    E_MEMADR    = mk(4'd2, 0,0,0,0,0,0,1, 2'b10, 4'b0010, 0, 2'b00, 0,0,0,0);
    E_MEMRD     = mk(4'd3, 1,0,0,0,0,0,0, 2'b00, 4'b0010, 0, 2'b00, 0,0,0,0);
    E_MEMWB     = mk(4'd4, 0,0,0,0,1,1,0, 2'b00, 4'b0010, 0, 2'b00, 0,0,0,0);
    E_MEMWR     = mk(4'd5, 1,1,0,0,0,0,0, 2'b00, 4'b0010, 0, 2'b00, 0,0,0,0);
    E_EXE       = mk(4'd6, 0,0,0,0,0,0,1, 2'b00, 4'b0000, 0, 2'b00, 0,0,0,0);
    E_ALUWB     = mk(4'd7, 0,0,0,1,0,1,0, 2'b00, 4'b0010, 0, 2'b00, 0,0,0,0);
    E_IMMWB     = mk(4'd10,0,0,0,0,0,1,0, 2'b00, 4'b0010, 0, 2'b00, 0,0,0,0);
    E_JUMP      = mk(4'd11,0,0,0,0,0,0,0, 2'b00, 4'b0010, 0, 2'b10, 1,0,0,0);
    E_MEMRD_RST = mk(4'd3, 1,0,0,0,0,0,0, 2'b00, 4'b0010, 0, 2'b00, 0,0,0,0);
  end

  // While reset is held: state 0 after the first edge, every strobe low.
  task automatic test_reset();
    reset  = 1'b1;
    opcode = 6'b000000;
    @(negedge clk);
    sb.push_back(E_RST);
    sb.push_back(E_RST);
    for (int i = 0; sb.size() > 0; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      exp_v = sb.pop_front();
      checks++;
      if (act_v !== exp_v) begin
        failures++;
        $display("FAIL reset[%0d] got=%h want=%h", i, act_v, exp_v);
      end
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if (act_v !== E_FETCH) begin
      failures++;
      $display("FAIL reset_release got=%h want=%h", act_v, E_FETCH);
    end
  endtask

  // lw: 0,1,2,3,4 then back to FETCH.
  task automatic test_lw();
    opcode = 6'b100011;
    sb.push_back(E_FETCH); sb.push_back(E_DEC); sb.push_back(E_MEMADR);
    sb.push_back(E_MEMRD); sb.push_back(E_MEMWB); sb.push_back(E_FETCH);
    for (int i = 0; sb.size() > 0; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      exp_v = sb.pop_front();
      checks++;
      if (act_v !== exp_v) begin
        failures++;
        $display("FAIL lw[%0d] got=%h want=%h", i, act_v, exp_v);
      end
    end
  endtask

  // sw: 0,1,2,5; MEMADR must present add, not 1011.
  task automatic test_sw();
    opcode = 6'b101011;
    sb.push_back(E_FETCH); sb.push_back(E_DEC); sb.push_back(E_MEMADR);
    sb.push_back(E_MEMWR); sb.push_back(E_FETCH);
    for (int i = 0; sb.size() > 0; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      exp_v = sb.pop_front();
      checks++;
      if (act_v !== exp_v) begin
        failures++;
        $display("FAIL sw[%0d] got=%h want=%h", i, act_v, exp_v);
      end
    end
  endtask

  // R-type: 0,1,6,7.
  task automatic test_rtype();
    opcode = 6'b000000;
    sb.push_back(E_FETCH); sb.push_back(E_DEC); sb.push_back(E_EXE);
    sb.push_back(E_ALUWB); sb.push_back(E_FETCH);
    for (int i = 0; sb.size() > 0; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      exp_v = sb.pop_front();
      checks++;
      if (act_v !== exp_v) begin
        failures++;
        $display("FAIL rtype[%0d] got=%h want=%h", i, act_v, exp_v);
      end
    end
  endtask

  // Immediate ops: 0,1,9,10 with alu_op/zero_ext given by the caller.
  task automatic test_imm(input logic [5:0] opc, input logic [3:0] aop,
                          input logic ze);
    opcode = opc;
    sb.push_back(E_FETCH); sb.push_back(E_DEC);
    sb.push_back(mk(4'd9, 0,0,0,0,0,0,1, 2'b10, aop, ze, 2'b00, 0,0,0,0));
    sb.push_back(E_IMMWB); sb.push_back(E_FETCH);
    for (int i = 0; sb.size() > 0; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      exp_v = sb.pop_front();
      checks++;
      if (act_v !== exp_v) begin
        failures++;
        $display("FAIL imm_%b[%0d] got=%h want=%h", opc, i, act_v, exp_v);
      end
    end
  endtask

  // beq/bne: 0,1,8 with the matching branch strobe.
  task automatic test_branch(input logic [5:0] opc, input logic [3:0] aop,
                             input logic br, input logic bn);
    opcode = opc;
    sb.push_back(E_FETCH); sb.push_back(E_DEC);
    sb.push_back(mk(4'd8, 0,0,0,0,0,0,1, 2'b00, aop, 0, 2'b01, 0, br, bn, 0));
    sb.push_back(E_FETCH);
    for (int i = 0; sb.size() > 0; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      exp_v = sb.pop_front();
      checks++;
      if (act_v !== exp_v) begin
        failures++;
        $display("FAIL branch_%b[%0d] got=%h want=%h", opc, i, act_v, exp_v);
      end
    end
  endtask

  // j: 0,1,11.
  task automatic test_jump();
    opcode = 6'b000010;
    sb.push_back(E_FETCH); sb.push_back(E_DEC); sb.push_back(E_JUMP);
    sb.push_back(E_FETCH);
    for (int i = 0; sb.size() > 0; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      exp_v = sb.pop_front();
      checks++;
      if (act_v !== exp_v) begin
        failures++;
        $display("FAIL jump[%0d] got=%h want=%h", i, act_v, exp_v);
      end
    end
  endtask

  // Unsupported opcode: one-cycle illegal_op pulse in DECODE, then FETCH.
  task automatic test_illegal(input logic [5:0] opc);
    opcode = opc;
    sb.push_back(E_FETCH); sb.push_back(E_DEC_ILL); sb.push_back(E_FETCH);
    sb.push_back(E_DEC_ILL);
    for (int i = 0; sb.size() > 0; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      exp_v = sb.pop_front();
      checks++;
      if (act_v !== exp_v) begin
        failures++;
        $display("FAIL illegal_%b[%0d] got=%h want=%h", opc, i, act_v, exp_v);
      end
    end
    // Next cycle is FETCH again; leave the opcode harmless for later tests.
    @(negedge clk);
    opcode = 6'b000000;
  endtask

  // Reset in MEMREAD of an lw: strobes low immediately, FETCH next, no write.
  task automatic test_reset_midinstr();
    int rw_seen = 0;
    opcode = 6'b100011;
    sb.push_back(E_FETCH); sb.push_back(E_DEC); sb.push_back(E_MEMADR);
    sb.push_back(E_MEMRD);
    for (int i = 0; sb.size() > 0; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      exp_v = sb.pop_front();
      checks++;
      if (act_v !== exp_v) begin
        failures++;
        $display("FAIL rst_mid[%0d] got=%h want=%h", i, act_v, exp_v);
      end
    end
    reset = 1'b1;
    sb.push_back(E_MEMRD_RST); sb.push_back(E_RST);
    for (int i = 0; sb.size() > 0; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      exp_v = sb.pop_front();
      if (reg_write) rw_seen++;
      checks++;
      if (act_v !== exp_v) begin
        failures++;
        $display("FAIL rst_mid_hold[%0d] got=%h want=%h", i, act_v, exp_v);
      end
    end
    reset = 1'b0;
    sb.push_back(E_FETCH); sb.push_back(E_DEC); sb.push_back(E_MEMADR);
    for (int i = 0; sb.size() > 0; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      exp_v = sb.pop_front();
      if (reg_write) rw_seen++;
      checks++;
      if (act_v !== exp_v) begin
        failures++;
        $display("FAIL rst_mid_after[%0d] got=%h want=%h", i, act_v, exp_v);
      end
    end
    checks++;
    if (rw_seen !== 0) begin
      failures++;
      $display("FAIL rst_mid_regwrite got=%0d want=0", rw_seen);
    end
    // Finish the restarted lw so the FSM is back in FETCH.
    sb.push_back(E_MEMRD); sb.push_back(E_MEMWB); sb.push_back(E_FETCH);
    for (int i = 0; sb.size() > 0; i++) begin
      @(negedge clk);
      #1;
      exp_v = sb.pop_front();
      checks++;
      if (act_v !== exp_v) begin
        failures++;
        $display("FAIL rst_mid_finish[%0d] got=%h want=%h", i, act_v, exp_v);
      end
    end
  endtask

  // Each task leaves the FSM in FETCH, sampled at negedge+1.
  initial begin
    test_reset();
    test_lw();
    test_sw();
    test_rtype();
    test_imm(6'b001101, 4'b1101, 1'b1);
    test_imm(6'b001010, 4'b1010, 1'b0);
    test_imm(6'b001011, 4'b1011, 1'b0);
    test_imm(6'b001100, 4'b1100, 1'b1);
    test_imm(6'b001000, 4'b1000, 1'b0);
    test_branch(6'b000101, 4'b0101, 1'b0, 1'b1);
    test_branch(6'b000100, 4'b0100, 1'b1, 1'b0);
    test_jump();
    test_illegal(6'b111111);
    #1;
    checks++;
    if (act_v !== E_FETCH) begin
      failures++;
      $display("FAIL illegal_return got=%h want=%h", act_v, E_FETCH);
    end
    test_reset_midinstr();
    test_sw();
    test_lw();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Watchdog against any unexpected stall of the stimulus process.
  initial begin
    #100000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
